// File: rtl/data_sram_pkg.sv
// Shared types and constants for the data SRAM responder: size encodings,
// outstanding-queue entry layout and parameter defaults.
package data_sram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_LATENCY    = 2;
  localparam int unsigned DEF_DEPTH      = 4;

  // Countdown wide enough for LATENCY up to 7.
  localparam int unsigned CD_W = 3;

  typedef struct packed {
    logic            wr;
    logic [31:0]     rdata;
    logic [CD_W-1:0] countdown;
  } resp_entry_t;

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// Outstanding-request queue: synchronous FIFO whose entries all count down
// (saturating at 0) every cycle, so the head knows when its response is due.
module resp_fifo
  import data_sram_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  resp_entry_t                  push_data_i,
  input  logic                         pop_i,
  output resp_entry_t                  head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  resp_entry_t       entries_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (entries_q[i].countdown != '0) begin
          entries_q[i].countdown <= entries_q[i].countdown - 1'b1;
        end
      end
      // Later assignment wins: a freshly pushed entry starts at its full countdown.
      if (push_i) begin
        entries_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign head_o  = entries_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/data_sram_responder.sv
// Fixed-latency, in-order data SRAM responder with up to DEPTH outstanding requests.
// Optional feature: define RESP_RANDOM_STALL_EN for LFSR-driven addr_ok stalls.
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [31:0]           mem_q [WORDS];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;
  logic                  stall;
  logic                  retire;
  resp_entry_t           push_entry;
  resp_entry_t           head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;

  assign word_idx = data_sram_addr[ADDR_WIDTH+1:2];

`ifdef RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall  = lfsr_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Reset gates the outputs combinationally so they are quiet from the moment it rises.
  assign accept = data_sram_req && (fifo_count < CW'(DEPTH)) && !stall && !reset;
  assign retire = !fifo_empty && (head.countdown == '0) && !reset;

  assign data_sram_addr_ok = accept;
  assign data_sram_data_ok = retire;
  assign data_sram_rdata   = (retire && !head.wr) ? head.rdata : '0;

  always_comb begin
    push_entry           = '0;
    push_entry.wr        = data_sram_wr;
    push_entry.rdata     = data_sram_wr ? '0 : mem_q[word_idx];
    push_entry.countdown = CD_W'(LATENCY - 1);
  end

  // Memory is deliberately not reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem_q[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  resp_fifo #(
    .DEPTH(DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (reset),
    .push_i     (accept),
    .push_data_i(push_entry),
    .pop_i      (retire),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  logic unused_ok;
  assign unused_ok = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0],
                       data_sram_size, fifo_full};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a response scoreboard.
// Define RESP_RANDOM_STALL_EN for both bench and RTL to exercise random stalls.
module tb_data_sram_responder;
  import data_sram_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 7;
  localparam int unsigned DEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  data_sram_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT),
    .DEPTH     (DEP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_wstrb  (wstrb),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [1024];
  int          checks = 0;
  int          errors = 0;
  bit          stall_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every data_ok must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("late_resp", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (data_ok === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_data_ok", {31'b0, data_ok}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_cycle", cyc, mon_e.due);
          check("resp_rdata", rdata, mon_e.wr ? 32'h0 : mon_e.rdata);
        end
      end else begin
        check("idle_rdata", rdata, 32'h0);
      end
      if (req === 1'b0) check("addr_ok_without_req", {31'b0, addr_ok}, 32'h0);
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int unsigned acc_edge);
    bit          ok;
    int unsigned idx;
    ok    = 0;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    size  = SZ_WORD;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (addr_ok === 1'b1) begin
        ok = 1;
        break;
      end
      if (sb.size() < DEP - 1) stall_seen = 1;
    end
    if (!ok) begin
      check("accept_timeout", {31'b0, addr_ok}, 32'h1);
      req      = 1'b0;
      acc_edge = 0;
      return;
    end
    @(posedge clk);
    #1;
    acc_edge = cyc;
    idx      = 32'(a[11:2]);
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      sb.push_back('{wr: 1'b1, rdata: 32'h0, due: cyc + LAT - 1});
    end else begin
      sb.push_back('{wr: 1'b0, rdata: model[idx], due: cyc + LAT - 1});
    end
    req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 32'(sb.size()), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, a1, a2, a3, a4;
    reset = 1'b1;
    req   = 1'b0;
    wr    = 1'b0;
    size  = SZ_WORD;
    wstrb = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;

    // Outputs quiet during reset even with a request pending.
    repeat (2) @(posedge clk);
    #1;
    req = 1'b1;
    @(negedge clk);
    check("rst_addr_ok", {31'b0, addr_ok}, 32'h0);
    check("rst_data_ok", {31'b0, data_ok}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    req   = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full write then read back.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, a1);
    drain();

    // Partial write onto a zero word, then a zero-strobe write that must not alter it.
    issue(1'b1, 32'h20, 32'h0, 4'hF, a0);
    issue(1'b1, 32'h22, 32'h00AB00AB, 4'b0100, a0);
    issue(1'b0, 32'h20, 32'h0, 4'h0, a0);
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, a0);
    issue(1'b0, 32'h23, 32'h0, 4'h0, a0);
    issue(1'b0, 32'hFFFFF020, 32'h0, 4'h0, a0);
    drain();
    check("partial_word_model", model[8], 32'h00AB0000);

    // Back-to-back reads of preloaded words.
    issue(1'b1, 32'h0, 32'h1, 4'hF, a0);
    issue(1'b1, 32'h4, 32'h2, 4'hF, a0);
    issue(1'b1, 32'h8, 32'h3, 4'hF, a0);
    drain();
    issue(1'b0, 32'h0, 32'h0, 4'h0, a0);
    issue(1'b0, 32'h4, 32'h0, 4'h0, a1);
    issue(1'b0, 32'h8, 32'h0, 4'h0, a2);
`ifndef RESP_RANDOM_STALL_EN
    check("b2b_accept_1", a1, a0 + 1);
    check("b2b_accept_2", a2, a1 + 1);
`endif
    drain();

    // Fill all DEPTH slots; acceptance resumes the cycle after the first retire.
    issue(1'b0, 32'h10, 32'h0, 4'h0, a0);
    issue(1'b0, 32'h0, 32'h0, 4'h0, a1);
    issue(1'b0, 32'h4, 32'h0, 4'h0, a2);
    issue(1'b0, 32'h8, 32'h0, 4'h0, a3);
    issue(1'b0, 32'h10, 32'h0, 4'h0, a4);
`ifndef RESP_RANDOM_STALL_EN
    check("fill_accept_3", a3, a0 + 3);
    check("refill_accept", a4, a0 + LAT + 1);
`endif
    drain();

    // Reset with three outstanding: responses are discarded, memory survives.
    issue(1'b0, 32'h0, 32'h0, 4'h0, a0);
    issue(1'b0, 32'h4, 32'h0, 4'h0, a1);
    issue(1'b0, 32'h8, 32'h0, 4'h0, a2);
    reset = 1'b1;
    sb.delete();
    req = 1'b1;
    @(negedge clk);
    check("midrst_addr_ok", {31'b0, addr_ok}, 32'h0);
    check("midrst_data_ok", {31'b0, data_ok}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, a0);
    drain();
    check("post_rst_word", model[4], 32'hDEADBEEF);

    // Random traffic over preloaded words.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, a0);
    drain();
    stall_seen = 0;
    for (int i = 0; i < 100; i++) begin
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom,
            4'($urandom_range(0, 15)), a0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
`ifdef RESP_RANDOM_STALL_EN
    check("stall_seen", {31'b0, stall_seen}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
